// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the sync bundle used for stage alignment.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync/blank bundle travelling alongside the pixel pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bundle_t;

  // Value held while idle or in reset: syncs deasserted, display blanked.
  localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-rate shift register that aligns sync/blank with the downstream RGB pipeline.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  sync_bundle_t din,
  output sync_bundle_t dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      sync_bundle_t stage_q [DEPTH];
      sync_bundle_t stage_d [DEPTH];

      // Shift one stage per pixel tick.
      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d[0] = din;
          for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
      end

      // Stage registers, reset to the idle bundle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= SYNC_IDLE;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel strobe, x/y counters, and delayed sync/blank for the DAC.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_tick,
  output logic             active,
  output logic             frame_start,
  output logic             vga_clk,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             sync_n
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_B  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_B  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 2) begin : g_bad_div
      $error("vga_timing: CLK_DIV must be at least 2");
    end
    if (PIPE_DELAY > 7) begin : g_bad_delay
      $error("vga_timing: PIPE_DELAY must be in 0..7");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;
  logic             vga_clk_q, vga_clk_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             frame_start_q, frame_start_d;
  sync_bundle_t     sync_q, sync_d;
  sync_bundle_t     raw_c;
  sync_bundle_t     dly_c;

  // Clock divider; strobe and DAC clock are decoded from the next count so both are registered.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end
    pix_tick_d = (div_cnt_d == DIV_LAST);
    vga_clk_d  = (div_cnt_d >= DIV_HALF);
  end

  // Raster counters; frame_start flags the step that lands on (0,0).
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (pix_tick_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Undelayed sync/active decoded from the current counters.
  always_comb begin
    raw_c        = SYNC_IDLE;
    raw_c.hs     = !((x_q >= HS_START) && (x_q < HS_END));
    raw_c.vs     = !((y_q >= VS_START) && (y_q < VS_END));
    raw_c.active = (x_q < H_ACT_B) && (y_q < V_ACT_B);
  end

  vga_delay_line #(
    .DEPTH(PIPE_DELAY)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_tick_q),
    .din  (raw_c),
    .dout (dly_c)
  );

  // Output stage for the delayed bundle.
  always_comb begin
    sync_d = dly_c;
  end

  // All timing state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_tick_q    <= 1'b0;
      vga_clk_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      sync_q        <= SYNC_IDLE;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_tick_q    <= pix_tick_d;
      vga_clk_q     <= vga_clk_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_tick    = pix_tick_q;
  assign active      = raw_c.active;
  assign frame_start = frame_start_q;
  assign vga_clk     = vga_clk_q;
  assign hsync       = sync_q.hs;
  assign vsync       = sync_q.vs;
  assign blank_n     = sync_q.active;
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: three vga_timing configurations against a cycle-count model.
module tb_vga_timing;

  logic clk;
  logic rst_a, rst_b, rst_c;
  bit   go;

  int n_cmp;
  int n_bad;

  // Instance A: default timing, CLK_DIV=2, PIPE_DELAY=2
  logic [9:0] x_a, y_a;
  logic pix_tick_a, active_a, frame_start_a, vga_clk_a, hsync_a, vsync_a, blank_n_a, sync_n_a;
  // Instance B: default timing, CLK_DIV=4, PIPE_DELAY=0
  logic [9:0] x_b, y_b;
  logic pix_tick_b, active_b, frame_start_b, vga_clk_b, hsync_b, vsync_b, blank_n_b, sync_n_b;
  // Instance C: tiny raster (15x8), CLK_DIV=3, PIPE_DELAY=3, so whole frames fit in the run
  logic [9:0] x_c, y_c;
  logic pix_tick_c, active_c, frame_start_c, vga_clk_c, hsync_c, vsync_c, blank_n_c, sync_n_c;

  vga_timing #(.CLK_DIV(2), .PIPE_DELAY(2)) dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .pix_tick(pix_tick_a), .active(active_a),
    .frame_start(frame_start_a), .vga_clk(vga_clk_a), .hsync(hsync_a), .vsync(vsync_a),
    .blank_n(blank_n_a), .sync_n(sync_n_a));

  vga_timing #(.CLK_DIV(4), .PIPE_DELAY(0)) dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .pix_tick(pix_tick_b), .active(active_b),
    .frame_start(frame_start_b), .vga_clk(vga_clk_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank_n(blank_n_b), .sync_n(sync_n_b));

  vga_timing #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
               .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(3)) dut_c (
    .clk(clk), .rst(rst_c), .x(x_c), .y(y_c), .pix_tick(pix_tick_c), .active(active_c),
    .frame_start(frame_start_c), .vga_clk(vga_clk_c), .hsync(hsync_c), .vsync(vsync_c),
    .blank_n(blank_n_c), .sync_n(sync_n_c));

  logic [27:0] obs_a, obs_b, obs_c;
  assign obs_a = {x_a, y_a, pix_tick_a, active_a, frame_start_a, vga_clk_a, hsync_a, vsync_a, blank_n_a, sync_n_a};
  assign obs_b = {x_b, y_b, pix_tick_b, active_b, frame_start_b, vga_clk_b, hsync_b, vsync_b, blank_n_b, sync_n_b};
  assign obs_c = {x_c, y_c, pix_tick_c, active_c, frame_start_c, vga_clk_c, hsync_c, vsync_c, blank_n_c, sync_n_c};

  // Clock edges elapsed since each instance left reset.
  longint n_a, n_b, n_c;
  always @(posedge clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) n_b <= 0; else n_b <= n_b + 1;
  always @(posedge clk or posedge rst_c) if (rst_c) n_c <= 0; else n_c <= n_c + 1;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected output vector after n clock edges out of reset, derived from pixel-count arithmetic.
  function automatic logic [27:0] exp_out(input longint d, input longint pd,
                                          input longint ha, input longint hfp, input longint hsw, input longint hbp,
                                          input longint va, input longint vfp, input longint vsw, input longint vbp,
                                          input longint n);
    longint ht, vt, p, dv, px, py, q, qx, qy;
    logic pt, act, fs, vc, hs, vs, bn;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    p   = n / d;
    dv  = n % d;
    px  = p % ht;
    py  = (p / ht) % vt;
    pt  = (dv == d - 1);
    vc  = (dv >= d / 2);
    fs  = (p > 0) && (p % (ht * vt) == 0) && (dv == 0);
    act = (px < ha) && (py < va);
    hs  = 1'b1;
    vs  = 1'b1;
    bn  = 1'b0;
    if (n > 0) begin
      q = (n - 1) / d - pd;
      if (q >= 0) begin
        qx = q % ht;
        qy = (q / ht) % vt;
        hs = !((qx >= ha + hfp) && (qx < ha + hfp + hsw));
        vs = !((qy >= va + vfp) && (qy < va + vfp + vsw));
        bn = (qx < ha) && (qy < va);
      end
    end
    return {10'(px), 10'(py), pt, act, fs, vc, hs, vs, bn, 1'b0};
  endfunction

  bit     hs_prev_a, bn_prev_a;
  int     hs_low_a, hs_low_b, fs_cnt_c;
  longint hs_first_b, fs_first_c;

  // Per-cycle comparison against the model plus hand-computed pins.
  always @(negedge clk) begin
    if (go) begin
      chk("a_model", 32'(obs_a), 32'(exp_out(2, 2, 640, 16, 96, 48, 480, 10, 2, 33, n_a)));
      chk("b_model", 32'(obs_b), 32'(exp_out(4, 0, 640, 16, 96, 48, 480, 10, 2, 33, n_b)));
      chk("c_model", 32'(obs_c), 32'(exp_out(3, 3, 8, 2, 3, 2, 4, 1, 2, 1, n_c)));

      if (n_a == 1599) chk("a_line_end", 32'({x_a, y_a}), 32'({10'd799, 10'd0}));
      if (n_a == 1600) chk("a_line_wrap", 32'({x_a, y_a}), 32'({10'd0, 10'd1}));
      if (blank_n_a && !bn_prev_a) chk("a_blank_rise_x", 32'(x_a), 32'd2);
      if (!blank_n_a && bn_prev_a && !rst_a) chk("a_blank_fall_x", 32'(x_a), 32'd642);
      if (!hsync_a && hs_prev_a) chk("a_hsync_fall_x", 32'(x_a), 32'd658);
      if (n_a == 0) hs_low_a = 0;
      else if (n_a <= 1610 && !hsync_a) hs_low_a++;
      if (n_a == 1610) chk("a_hsync_low_clks", 32'(hs_low_a), 32'd192);
      hs_prev_a = hsync_a;
      bn_prev_a = blank_n_a;

      if (n_b == 0) begin
        hs_low_b   = 0;
        hs_first_b = 0;
      end else if (n_b <= 3200 && !hsync_b) begin
        hs_low_b++;
        if (hs_first_b == 0) hs_first_b = n_b;
      end
      if (n_b == 3200) begin
        chk("b_hsync_low_clks", 32'(hs_low_b), 32'd384);
        chk("b_hsync_first_clk", 32'(hs_first_b), 32'd2625);
      end

      if (n_c == 0) begin
        fs_cnt_c   = 0;
        fs_first_c = 0;
      end else if (n_c <= 719 && frame_start_c) begin
        fs_cnt_c++;
        if (fs_first_c == 0) fs_first_c = n_c;
      end
      if (frame_start_c) chk("c_fs_at_origin", 32'({x_c, y_c}), 32'd0);
      if (n_c == 719) begin
        chk("c_fs_count", 32'(fs_cnt_c), 32'd1);
        chk("c_fs_period", 32'(fs_first_c), 32'd360);
      end
    end
  end

  initial begin
    bit found;
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (4) @(posedge clk);
    go = 1'b1;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    fork
      begin
        // Mid-frame reset of the tiny raster at a random point.
        repeat (800 + $urandom_range(0, 300)) @(posedge clk);
        #3;
        rst_c = 1'b1;
        #1;
        chk("c_async_rst", 32'(obs_c),
            32'({10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        repeat (3) @(posedge clk);
        #1;
        rst_c = 1'b0;
      end
      repeat (3400) @(posedge clk);
    join

    // Reset instance A when it reaches x=300.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (x_a == 10'd300) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL a_wait_x300: x never reached 300, last x=%0d", x_a);
    end
    #2;
    rst_a = 1'b1;
    #1;
    chk("a_async_rst", 32'(obs_a),
        32'({10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    repeat (1700) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
